// File: rtl/fetch_ifid_pkg.sv
// Shared constants, state encoding and skid-entry payload for the fetch / IF-ID slice.
package fetch_ifid_pkg;

  localparam int unsigned XLEN  = 16;
  localparam int unsigned OPC_W = 5;

  localparam logic [XLEN-1:0]  RESET_PC  = 16'h0000;
  localparam logic [XLEN-1:0]  NOP_INSTR = 16'h0800;
  localparam logic [OPC_W-1:0] OPC_HALT  = 5'b00000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10,
    ST_HALT = 2'b11
  } fetch_state_e;

  // One parked fetch: the word, its PC+2, and whether it was a HALT.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcp2;
    logic            halt;
  } skid_t;

  function automatic logic is_halt_word(input logic [XLEN-1:0] w);
    return w[XLEN-1 -: OPC_W] == OPC_HALT;
  endfunction

endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register with load, hold and flush-to-NOP controls.
//  clk, rst_n      : clock, async active-low reset
//  flush           : replace contents with a NOP bubble (wins over load)
//  load            : capture load_instr/load_pcp2 as a valid instruction
//  load_instr/pcp2 : incoming instruction and its PC+2
//  instr/pcp2/valid: registered outputs to decode
module ifid_latch
  import fetch_ifid_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pcp2,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pcp2,
  output logic            valid
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcp2_q, pcp2_d;
  logic            valid_q, valid_d;

  // Next contents: hold by default; a bubble keeps the stale PC+2.
  always_comb begin
    instr_d = instr_q;
    pcp2_d  = pcp2_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = load_instr;
      pcp2_d  = load_pcp2;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pcp2_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pcp2_q  <= pcp2_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pcp2  = pcp2_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_ifid.sv
// Instruction fetch stage: PC, imem handshake, one-entry skid buffer for
// stalls, redirect/flush handling and HALT stop, feeding the IF/ID latch.
//  clk, rst          : clock, async active-low reset
//  stall             : decode hazard stall, hold IF/ID
//  redirect/_pc      : taken branch/jump and its target
//  imem_rd/addr      : read request and fetch address (= PC)
//  imem_rdy/data/err : same-cycle completion, instruction word, fault flag
//  IFID_*            : latched instruction, its PC+2, valid (0 = bubble)
//  halted, err       : fetch stopped on HALT, sticky fetch fault
module fetch_ifid
  import fetch_ifid_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        imem_err,
  output logic [15:0] IFID_instruction,
  output logic [15:0] IFID_PCplus2,
  output logic        IFID_valid,
  output logic        halted,
  output logic        err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  skid_t           skid_q, skid_d;
  logic            err_q, err_d;
  logic            imem_rd_q, imem_rd_d;
  logic            halted_q, halted_d;

  logic            rd_c;
  logic            comp_c;
  logic            hit_c;
  logic [XLEN-1:0] pc_plus2_c;
  logic            lat_load_c;
  logic            lat_flush_c;
  logic [XLEN-1:0] lat_instr_c;
  logic [XLEN-1:0] lat_pcp2_c;

  assign rd_c       = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign comp_c     = rd_c & imem_rdy;
  assign hit_c      = is_halt_word(imem_data);
  assign pc_plus2_c = pc_q + XLEN'(2);

  // Next state, PC, skid and IF/ID controls. Redirect overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    skid_d      = skid_q;
    err_d       = err_q;
    lat_load_c  = 1'b0;
    lat_flush_c = 1'b0;
    lat_instr_c = imem_data;
    lat_pcp2_c  = pc_plus2_c;

    if (redirect) begin
      pc_d        = redirect_pc;
      skid_d      = '0;
      lat_flush_c = 1'b1;
      state_d     = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN, ST_WAIT: begin
          if (comp_c) begin
            err_d = err_q | imem_err;
            // A HALT word is delivered but the PC parks on it.
            pc_d  = hit_c ? pc_q : pc_plus2_c;
            if (stall) begin
              skid_d  = '{instr: imem_data, pcp2: pc_plus2_c, halt: hit_c};
              state_d = ST_HOLD;
            end else begin
              lat_load_c = 1'b1;
              state_d    = hit_c ? ST_HALT : ST_RUN;
            end
          end else begin
            state_d     = ST_WAIT;
            lat_flush_c = ~stall;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            lat_load_c  = 1'b1;
            lat_instr_c = skid_q.instr;
            lat_pcp2_c  = skid_q.pcp2;
            state_d     = skid_q.halt ? ST_HALT : ST_RUN;
          end
        end
        ST_HALT: begin
          lat_flush_c = ~stall;
        end
      endcase
    end

    imem_rd_d = (state_d == ST_RUN) || (state_d == ST_WAIT);
    halted_d  = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      skid_q    <= '0;
      err_q     <= 1'b0;
      imem_rd_q <= 1'b1;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      skid_q    <= skid_d;
      err_q     <= err_d;
      imem_rd_q <= imem_rd_d;
      halted_q  <= halted_d;
    end
  end

  ifid_latch u_ifid_latch (
    .clk        (clk),
    .rst_n      (rst),
    .flush      (lat_flush_c),
    .load       (lat_load_c),
    .load_instr (lat_instr_c),
    .load_pcp2  (lat_pcp2_c),
    .instr      (IFID_instruction),
    .pcp2       (IFID_PCplus2),
    .valid      (IFID_valid)
  );

  assign imem_rd   = imem_rd_q;
  assign imem_addr = pc_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed bench for fetch_ifid. Memory returns {5'b00010, addr[11:1]} for
// every address except halt_addr, which returns the HALT word 16'h0005.
module tb_fetch_ifid;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        imem_err;
  logic [15:0] IFID_instruction;
  logic [15:0] IFID_PCplus2;
  logic        IFID_valid;
  logic        halted;
  logic        err;
  logic [15:0] halt_addr;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr == halt_addr) imem_data = 16'h0005;
    else                        imem_data = {5'b00010, imem_addr[11:1]};
  end

  fetch_ifid dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .imem_rd          (imem_rd),
    .imem_addr        (imem_addr),
    .imem_rdy         (imem_rdy),
    .imem_data        (imem_data),
    .imem_err         (imem_err),
    .IFID_instruction (IFID_instruction),
    .IFID_PCplus2     (IFID_PCplus2),
    .IFID_valid       (IFID_valid),
    .halted           (halted),
    .err              (err)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rdy = 1'b1; imem_err = 1'b0; halt_addr = 16'h1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd",     16'(imem_rd),    16'h1);
    chk("rst_addr",   imem_addr,       16'h0000);
    chk("rst_instr",  IFID_instruction, 16'h0800);
    chk("rst_pcp2",   IFID_PCplus2,    16'h0000);
    chk("rst_valid",  16'(IFID_valid), 16'h0);
    chk("rst_halted", 16'(halted),     16'h0);
    chk("rst_err",    16'(err),        16'h0);
    @(negedge clk);
    rst = 1'b1;

    // Straight line
    step();
    chk("t1_instr0", IFID_instruction, 16'h1000);
    chk("t1_pcp2_0", IFID_PCplus2,    16'h0002);
    chk("t1_valid0", 16'(IFID_valid), 16'h1);
    step();
    chk("t1_pcp2_1", IFID_PCplus2,    16'h0004);
    step();
    chk("t1_pcp2_2", IFID_PCplus2,    16'h0006);
    chk("t1_addr",   imem_addr,       16'h0006);

    // Back to PC=4, then memory not ready for two cycles
    redirect = 1'b1; redirect_pc = 16'h0004;
    step();
    redirect = 1'b0;
    chk("rd4_valid", 16'(IFID_valid), 16'h0);
    chk("rd4_instr", IFID_instruction, 16'h0800);
    chk("rd4_addr",  imem_addr,       16'h0004);
    imem_rdy = 1'b0;
    step();
    chk("t2_valid_a", 16'(IFID_valid), 16'h0);
    chk("t2_addr_a",  imem_addr,       16'h0004);
    chk("t2_rd_a",    16'(imem_rd),    16'h1);
    step();
    chk("t2_valid_b", 16'(IFID_valid), 16'h0);
    chk("t2_addr_b",  imem_addr,       16'h0004);
    imem_rdy = 1'b1;
    step();
    chk("t2_instr", IFID_instruction, 16'h1002);
    chk("t2_pcp2",  IFID_PCplus2,    16'h0006);
    chk("t2_valid", 16'(IFID_valid), 16'h1);
    step();
    chk("t2_instr6", IFID_instruction, 16'h1003);
    chk("t2_addr8",  imem_addr,       16'h0008);

    // Stall three cycles while the fetch at 8 completes
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_instr", IFID_instruction, 16'h1003);
      chk("t3_hold_pcp2",  IFID_PCplus2,    16'h0008);
      chk("t3_hold_rd",    16'(imem_rd),    16'h0);
      chk("t3_hold_addr",  imem_addr,       16'h000A);
    end
    stall = 1'b0;
    step();
    chk("t3_instr8", IFID_instruction, 16'h1004);
    chk("t3_pcp2",   IFID_PCplus2,    16'h000A);
    chk("t3_rd",     16'(imem_rd),    16'h1);
    chk("t3_addr",   imem_addr,       16'h000A);
    step();
    chk("t3_instr10", IFID_instruction, 16'h1005);
    chk("t3_pcp2_12", IFID_PCplus2,    16'h000C);

    // Redirect while HOLD: skid word at 12 is lost
    stall = 1'b1;
    step();
    chk("t4_hold_rd", 16'(imem_rd), 16'h0);
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("t4_valid", 16'(IFID_valid), 16'h0);
    chk("t4_instr", IFID_instruction, 16'h0800);
    chk("t4_addr",  imem_addr,       16'h0040);
    chk("t4_rd",    16'(imem_rd),    16'h1);
    step();
    chk("t4_instr40", IFID_instruction, 16'h1020);
    chk("t4_pcp2",    IFID_PCplus2,    16'h0042);

    // HALT word at 12
    redirect = 1'b1; redirect_pc = 16'h000C;
    step();
    redirect = 1'b0; halt_addr = 16'h000C;
    step();
    chk("t5_instr",  IFID_instruction, 16'h0005);
    chk("t5_pcp2",   IFID_PCplus2,    16'h000E);
    chk("t5_valid",  16'(IFID_valid), 16'h1);
    chk("t5_halted", 16'(halted),     16'h1);
    chk("t5_rd",     16'(imem_rd),    16'h0);
    chk("t5_addr",   imem_addr,       16'h000C);
    step();
    chk("t5_bubble",  16'(IFID_valid), 16'h0);
    chk("t5_halted2", 16'(halted),     16'h1);
    chk("t5_addr2",   imem_addr,       16'h000C);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    chk("t5_unhalt", 16'(halted),  16'h0);
    chk("t5_rd2",    16'(imem_rd), 16'h1);
    chk("t5_addr20", imem_addr,    16'h0020);
    step();
    chk("t5_instr20", IFID_instruction, 16'h1010);
    chk("t5_pcp2_22", IFID_PCplus2,    16'h0022);

    // Fault at FFFE, PC wraps, err sticky until async reset
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0; imem_err = 1'b1;
    step();
    imem_err = 1'b0;
    chk("t6_instr", IFID_instruction, 16'h17FF);
    chk("t6_pcp2",  IFID_PCplus2,    16'h0000);
    chk("t6_err",   16'(err),        16'h1);
    chk("t6_addr",  imem_addr,       16'h0000);
    step();
    chk("t6_err_sticky", 16'(err),        16'h1);
    chk("t6_instr0",     IFID_instruction, 16'h1000);
    chk("t6_pcp2_2",     IFID_PCplus2,    16'h0002);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_err",   16'(err),         16'h0);
    chk("t6_rst_valid", 16'(IFID_valid),  16'h0);
    chk("t6_rst_instr", IFID_instruction, 16'h0800);
    chk("t6_rst_addr",  imem_addr,        16'h0000);
    @(negedge clk);
    rst = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
